// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the multi-cycle core: immediate formats, opcodes,
// the canonical NOP and the extension sequencer state type.
package riscv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_HOLD = 2'd2
  } ext_state_e;

endpackage

// File: rtl/imm_ext_unit_if.sv
// Bus between the core control/memory side and the IR + immediate extension unit.
// The master drives the fetch strobe and decoder code; the slave returns IR and ImmExt.
interface imm_ext_unit_if #(
  parameter int XLEN = 32
);
  logic            ir_write;
  logic [XLEN-1:0] instr_in;
  logic [XLEN-1:0] pc_in;
  logic [2:0]      immsrc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] old_pc;
  logic [XLEN-1:0] imm_ext;
  logic            imm_valid;
  logic            imm_err;

  modport master (
    output ir_write, instr_in, pc_in, immsrc,
    input  instr, old_pc, imm_ext, imm_valid, imm_err
  );

  modport slave (
    input  ir_write, instr_in, pc_in, immsrc,
    output instr, old_pc, imm_ext, imm_valid, imm_err
  );
endinterface

// File: rtl/imm_sel.sv
// Combinational immediate selector: picks and sign-replicates IR bits per format.
// Any code outside I/S/B/J/U (including unknown bits) yields zero and flags illegal.
module imm_sel
  import riscv_pkg::*;
(
  input  logic               [31:7] instr_hi,
  input  logic               [2:0]  immsrc,
  output logic signed        [31:0] imm,
  output logic                      illegal
);

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I: imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
      IMM_S: imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      IMM_B: imm = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                    instr_hi[30:25], instr_hi[11:8], 1'b0};
      IMM_J: imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                    instr_hi[20], instr_hi[30:21], 1'b0};
      IMM_U: imm = {instr_hi[31:12], 12'b0};
      // case equality means X/Z codes also fall through to here
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Instruction register, old-PC register and registered immediate extension
// for the multi-cycle RV32I core, sequenced by a small IDLE/EXT/HOLD FSM.
module imm_ext_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  imm_ext_unit_if.slave bus
);

  ext_state_e state_q, state_d;
  logic       ir_ld, ext_ld;

  logic [XLEN-1:0]   instr_p0, old_pc_p0;
  logic signed [31:0] imm_ext_p1;
  logic               vld_p1, err_p1;

  logic signed [31:0] imm_w;
  logic               illegal_w;

  imm_sel u_imm_sel (
    .instr_hi (instr_p0[31:7]),
    .immsrc   (bus.immsrc),
    .imm      (imm_w),
    .illegal  (illegal_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A new strobe always wins, so a reload in EXT discards the pending extension.
  always_comb begin
    state_d = state_q;
    ir_ld   = 1'b0;
    ext_ld  = 1'b0;
    if (bus.ir_write) begin
      state_d = ST_EXT;
      ir_ld   = 1'b1;
    end else begin
      case (state_q)
        ST_EXT: begin
          state_d = ST_HOLD;
          ext_ld  = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Stage p0: IR and old-PC capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p0  <= NOP;
      old_pc_p0 <= RESET_PC;
    end else if (ir_ld) begin
      instr_p0  <= bus.instr_in;
      old_pc_p0 <= bus.pc_in;
    end
  end

  // Stage p1: extended immediate and its flags; imm_ext only moves on EXT->HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_ext_p1 <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
    end else if (ir_ld) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (ext_ld) begin
      imm_ext_p1 <= imm_w;
      vld_p1     <= 1'b1;
      err_p1     <= illegal_w;
    end
  end

  assign bus.instr     = instr_p0;
  assign bus.old_pc    = old_pc_p0;
  assign bus.imm_ext   = imm_ext_p1;
  assign bus.imm_valid = vld_p1;
  assign bus.imm_err   = err_p1;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: vector table of loads plus hand-written
// sequences for back-to-back strobes, the immsrc sampling window and async reset.
module tb_imm_ext_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imm_ext_unit_if bif ();

  imm_ext_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [2:0]  src;
    logic [31:0] exp_imm;
    logic        exp_err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a load for one edge, then drop the strobe and sample #1 after the edge.
  task automatic strobe(input logic [31:0] ins, input logic [31:0] pc, input logic [2:0] src);
    bif.ir_write = 1'b1;
    bif.instr_in = ins;
    bif.pc_in    = pc;
    bif.immsrc   = src;
    @(posedge clk);
    #1;
    bif.ir_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev_imm;

    vt[0]  = '{32'hFFF00093, 32'h0000_0000, 3'b000, 32'hFFFFFFFF, 1'b0};
    vt[1]  = '{32'h0020A423, 32'h0000_0004, 3'b001, 32'h00000008, 1'b0};
    vt[2]  = '{32'hFE000EE3, 32'h0000_0008, 3'b010, 32'hFFFFFFFC, 1'b0};
    vt[3]  = '{32'h001000EF, 32'h0000_000C, 3'b011, 32'h00000800, 1'b0};
    vt[4]  = '{32'h123452B7, 32'h0000_0010, 3'b100, 32'h12345000, 1'b0};
    vt[5]  = '{32'hFFF00093, 32'h0000_0014, 3'b110, 32'h00000000, 1'b1};
    vt[6]  = '{32'h7FF00013, 32'h0000_0018, 3'b000, 32'h000007FF, 1'b0};
    vt[7]  = '{32'h800000EF, 32'h0000_001C, 3'b011, 32'hFFF00000, 1'b0};
    vt[8]  = '{32'h80000537, 32'h8000_0020, 3'b111, 32'h00000000, 1'b1};
    vt[9]  = '{32'h80000537, 32'h8000_0024, 3'b101, 32'h00000000, 1'b1};
    vt[10] = '{32'h80000537, 32'hFFFF_FFFC, 3'b100, 32'h80000000, 1'b0};

    bif.ir_write = 1'b0;
    bif.instr_in = '0;
    bif.pc_in    = '0;
    bif.immsrc   = 3'b000;

    // Reset values
    step();
    chk("rst_instr",   bif.instr,     32'h00000013);
    chk("rst_old_pc",  bif.old_pc,    32'h0);
    chk("rst_imm_ext", bif.imm_ext,   32'h0);
    chk("rst_valid",   {31'b0, bif.imm_valid}, 32'h0);
    chk("rst_err",     {31'b0, bif.imm_err},   32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", {31'b0, bif.imm_valid}, 32'h0);

    // Vector table: load, check IR side, then one cycle later check the immediate
    for (int k = 0; k < 11; k++) begin
      strobe(vt[k].ins, vt[k].pc, vt[k].src);
      chk($sformatf("v%0d_instr", k),  bif.instr,  vt[k].ins);
      chk($sformatf("v%0d_old_pc", k), bif.old_pc, vt[k].pc);
      chk($sformatf("v%0d_vld_lo", k), {31'b0, bif.imm_valid}, 32'h0);
      chk($sformatf("v%0d_err_lo", k), {31'b0, bif.imm_err},   32'h0);
      step();
      chk($sformatf("v%0d_imm", k),    bif.imm_ext, vt[k].exp_imm);
      chk($sformatf("v%0d_vld", k),    {31'b0, bif.imm_valid}, 32'h1);
      chk($sformatf("v%0d_err", k),    {31'b0, bif.imm_err},   {31'b0, vt[k].exp_err});
    end

    // immsrc changes during HOLD must not disturb imm_ext
    bif.immsrc = 3'b001;
    step();
    step();
    chk("hold_imm",   bif.imm_ext, 32'h80000000);
    chk("hold_valid", {31'b0, bif.imm_valid}, 32'h1);

    // Only the immsrc present in the EXT cycle is used (U at strobe, I in EXT)
    strobe(32'hFFF00093, 32'h0000_0040, 3'b100);
    bif.immsrc = 3'b000;
    step();
    chk("window_imm", bif.imm_ext, 32'hFFFFFFFF);
    prev_imm = 32'hFFFFFFFF;

    // Back-to-back strobes: addi @0x10 then lui @0x14
    bif.ir_write = 1'b1;
    bif.instr_in = 32'hFFF00093;
    bif.pc_in    = 32'h10;
    bif.immsrc   = 3'b000;
    step();
    chk("b2b_vld_1",  {31'b0, bif.imm_valid}, 32'h0);
    chk("b2b_instr1", bif.instr, 32'hFFF00093);
    bif.instr_in = 32'h123452B7;
    bif.pc_in    = 32'h14;
    bif.immsrc   = 3'b100;
    step();
    bif.ir_write = 1'b0;
    chk("b2b_vld_2",  {31'b0, bif.imm_valid}, 32'h0);
    chk("b2b_imm_2",  bif.imm_ext, prev_imm);
    chk("b2b_old_pc", bif.old_pc, 32'h14);
    step();
    chk("b2b_imm",    bif.imm_ext, 32'h12345000);
    chk("b2b_vld",    {31'b0, bif.imm_valid}, 32'h1);
    chk("b2b_instr",  bif.instr, 32'h123452B7);

    // Async reset while in EXT: outputs clear before the next edge
    strobe(32'h0020A423, 32'h0000_0080, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_instr",   bif.instr,   32'h00000013);
    chk("arst_old_pc",  bif.old_pc,  32'h0);
    chk("arst_imm_ext", bif.imm_ext, 32'h0);
    chk("arst_valid",   {31'b0, bif.imm_valid}, 32'h0);
    chk("arst_err",     {31'b0, bif.imm_err},   32'h0);
    step();
    rst_n = 1'b1;
    // The aborted extension must not complete after reset release
    step();
    step();
    chk("arst_idle_valid", {31'b0, bif.imm_valid}, 32'h0);
    chk("arst_idle_imm",   bif.imm_ext, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
